// File: rtl/config_arb_pkg.sv
// Shared state encoding and width helper for the config bus arbiter.
package config_arb_pkg;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} arb_state_e;

   // Ceiling log2, never below 1 so that degenerate counters still have a bit.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 1;
      while ((64'd1 << width) < 64'(value)) width++;
      return width;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first active request after i_last, wrapping.
module rr_arbiter
   import config_arb_pkg::*;
#(
   parameter int unsigned N = 2,
   localparam int unsigned IdxW = clog2(N)
) (
   input  logic [N-1:0]    i_req,
   input  logic [IdxW-1:0] i_last,
   output logic            o_valid,
   output logic [N-1:0]    o_grant,
   output logic [IdxW-1:0] o_idx
);

   logic [IdxW-1:0] w_cand;

   always_comb begin
      o_valid = 1'b0;
      o_grant = '0;
      o_idx   = '0;
      w_cand  = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         w_cand = IdxW'((32'(i_last) + k) % N);
         if (!o_valid && i_req[w_cand]) begin
            o_valid          = 1'b1;
            o_idx            = w_cand;
            o_grant[w_cand]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/config_bus_arbiter.sv
// Shares one core config port between N_REQ requesters, one transaction at a time,
// with round-robin acceptance, single-cycle writes and fixed-latency reads.
module config_bus_arbiter
   import config_arb_pkg::*;
#(
   parameter int unsigned N_REQ        = 2,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned READ_LATENCY = 0
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [N_REQ-1:0]            i_req_valid,
   output logic [N_REQ-1:0]            o_req_ready,
   input  logic [N_REQ-1:0]            i_req_write,
   input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [N_REQ-1:0]            o_rsp_valid,
   output logic [DATA_WIDTH-1:0]       o_rsp_data,
   output logic                        o_busy,
   output logic [ADDR_WIDTH-1:0]       o_config_config_addr,
   output logic [DATA_WIDTH-1:0]       o_config_config_data,
   output logic                        o_config_read,
   output logic                        o_config_write,
   input  logic [DATA_WIDTH-1:0]       i_read_config_data
);

   localparam int unsigned IDX_W = clog2(N_REQ);
   localparam int unsigned CNT_W = clog2(READ_LATENCY + 1);

   arb_state_e            r_state, w_state_next;
   logic [IDX_W-1:0]      r_last;
   logic [N_REQ-1:0]      r_gnt;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic [CNT_W-1:0]      r_cnt;

   logic                  w_any;
   logic [N_REQ-1:0]      w_gnt;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_sel_write;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_data;

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr_arbiter (
      .i_req   (i_req_valid),
      .i_last  (r_last),
      .o_valid (w_any),
      .o_grant (w_gnt),
      .o_idx   (w_idx)
   );

   always_comb begin
      w_sel_write = 1'b0;
      w_sel_addr  = '0;
      w_sel_data  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (w_gnt[i]) begin
            w_sel_write = i_req_write[i];
            w_sel_addr  = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_sel_data  = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= StIdle;
      else          r_state <= w_state_next;
   end

   // Accept pulse is masked by reset so every output is 0 while reset is held.
   always_comb begin
      w_state_next   = r_state;
      o_req_ready    = '0;
      o_rsp_valid    = '0;
      o_config_read  = 1'b0;
      o_config_write = 1'b0;
      o_busy         = 1'b1;
      unique case (r_state)
         StIdle: begin
            o_busy = 1'b0;
            if (w_any && i_rst_n) begin
               o_req_ready  = w_gnt;
               w_state_next = StIssue;
            end
         end
         StIssue: begin
            if (r_write) begin
               o_config_write = 1'b1;
               w_state_next   = StResp;
            end else begin
               o_config_read = 1'b1;
               w_state_next  = (READ_LATENCY == 0) ? StResp : StWait;
            end
         end
         StWait: begin
            o_config_read = 1'b1;
            if (r_cnt == CNT_W'(1)) w_state_next = StResp;
         end
         StResp: begin
            o_rsp_valid  = r_gnt;
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last     <= IDX_W'(N_REQ - 1);
         r_gnt      <= '0;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_rsp_data <= '0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_any) begin
                  r_last  <= w_idx;
                  r_gnt   <= w_gnt;
                  r_write <= w_sel_write;
                  r_addr  <= w_sel_addr;
                  r_data  <= w_sel_data;
               end
            end
            StIssue: begin
               if (r_write)                 r_rsp_data <= '0;
               else if (READ_LATENCY == 0)  r_rsp_data <= i_read_config_data;
               else                         r_cnt      <= CNT_W'(READ_LATENCY);
            end
            StWait: begin
               if (r_cnt == CNT_W'(1)) r_rsp_data <= i_read_config_data;
               else                    r_cnt      <= r_cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign o_rsp_data           = r_rsp_data;
   assign o_config_config_addr = r_addr;
   assign o_config_config_data = r_data;

endmodule

// File: tb/tb_config_bus_arbiter.sv
// Bench for config_bus_arbiter: a zero-latency instance (table + random vs. model)
// and a two-cycle-latency instance (latency and asynchronous reset sequences).
module tb_config_bus_arbiter;

   localparam logic [31:0] D = 32'hDEADBEEF;
   localparam logic [31:0] E = 32'h12345678;
   localparam logic [31:0] C = 32'hCAFEF00D;

   typedef struct packed {
      logic [1:0]  rdy;
      logic [1:0]  rv;
      logic [31:0] rd;
      logic        bsy;
      logic        crd;
      logic        cwr;
      logic [7:0]  ca;
      logic [31:0] cd;
   } obs_t;

   typedef struct {
      logic [1:0]  v;
      logic [1:0]  w;
      logic [7:0]  a0;
      logic [31:0] d0;
      logic [7:0]  a1;
      logic [31:0] d1;
      obs_t        exp;
   } row_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] cyc = '0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   int n_checks = 0;
   int n_fail   = 0;

   // Instance A: READ_LATENCY = 0
   logic        rst_a_n;
   logic [1:0]  v_a, w_a, rdy_a, rv_a;
   logic [15:0] addr_a;
   logic [63:0] data_a;
   logic [31:0] rd_a, cd_a, rcd_a;
   logic        bsy_a, crd_a, cwr_a;
   logic [7:0]  ca_a;
   logic [31:0] mem_a [256];
   obs_t        obs_a;

   // Instance B: READ_LATENCY = 2
   logic        rst_b_n;
   logic [1:0]  v_b, w_b, rdy_b, rv_b;
   logic [15:0] addr_b;
   logic [63:0] data_b;
   logic [31:0] rd_b, cd_b, rcd_b;
   logic        bsy_b, crd_b, cwr_b;
   logic [7:0]  ca_b;

   config_bus_arbiter #(
      .N_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(0)
   ) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_a_n), .i_req_valid(v_a), .o_req_ready(rdy_a),
      .i_req_write(w_a), .i_req_addr(addr_a), .i_req_data(data_a),
      .o_rsp_valid(rv_a), .o_rsp_data(rd_a), .o_busy(bsy_a),
      .o_config_config_addr(ca_a), .o_config_config_data(cd_a),
      .o_config_read(crd_a), .o_config_write(cwr_a), .i_read_config_data(rcd_a)
   );

   config_bus_arbiter #(
      .N_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(2)
   ) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_b_n), .i_req_valid(v_b), .o_req_ready(rdy_b),
      .i_req_write(w_b), .i_req_addr(addr_b), .i_req_data(data_b),
      .o_rsp_valid(rv_b), .o_rsp_data(rd_b), .o_busy(bsy_b),
      .o_config_config_addr(ca_b), .o_config_config_data(cd_b),
      .o_config_read(crd_b), .o_config_write(cwr_b), .i_read_config_data(rcd_b)
   );

   // Core behind A: plain register file with a combinational read mux.
   initial for (int i = 0; i < 256; i++) mem_a[i] = '0;
   always @(posedge clk) if (cwr_a) mem_a[ca_a] <= cd_a;
   assign rcd_a = mem_a[ca_a];
   assign obs_a = {rdy_a, rv_a, rd_a, bsy_a, crd_a, cwr_a, ca_a, cd_a};

   // Core behind B: data changes every cycle so the capture cycle is visible.
   assign rcd_b = {24'h0, ca_b} + cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got rdy=%b rv=%b rd=%h bsy/crd/cwr=%b%b%b ca=%h cd=%h, expected rdy=%b rv=%b rd=%h bsy/crd/cwr=%b%b%b ca=%h cd=%h",
                  name, act.rdy, act.rv, act.rd, act.bsy, act.crd, act.cwr, act.ca, act.cd,
                  exp.rdy, exp.rv, exp.rd, exp.bsy, exp.crd, exp.cwr, exp.ca, exp.cd);
      end
   endtask

   function automatic row_t mk(input logic [1:0] v, input logic [1:0] w,
                               input logic [7:0] a0, input logic [31:0] d0,
                               input logic [7:0] a1, input logic [31:0] d1,
                               input logic [1:0] rdy, input logic [1:0] rv,
                               input logic [31:0] rd, input logic [2:0] bcw,
                               input logic [7:0] ca, input logic [31:0] cd);
      row_t r;
      r.v = v; r.w = w; r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1;
      r.exp = {rdy, rv, rd, bcw, ca, cd};
      return r;
   endfunction

   // Round robin by definition: first valid index after the last winner.
   function automatic int rr_pick(input logic [1:0] v, input int last);
      for (int k = 1; k <= 2; k++) if (v[(last + k) % 2]) return (last + k) % 2;
      return -1;
   endfunction

   row_t        tbl[$];
   logic [31:0] model_mem [256];

   initial begin
      int          m_phase, m_last, m_g;
      logic        m_w;
      logic [7:0]  m_ca;
      logic [31:0] m_cd, m_rd;
      logic [1:0]  acc;
      logic [31:0] c0;
      obs_t        exp_o;

      rst_a_n = 1'b0; rst_b_n = 1'b0;
      v_a = 2'b11; w_a = '0; addr_a = '0; data_a = '0;
      v_b = 2'b11; w_b = '0; addr_b = '0; data_b = '0;

      // Test 1: both write; test 2: req1 reads back; test 3: alternation; test 6: back-to-back
      tbl.push_back(mk(2'b11, 2'b11, 8'h01, D, 8'h00, E, 2'b01, 2'b00, 32'h0, 3'b000, 8'h00, 32'h0));
      tbl.push_back(mk(2'b10, 2'b11, 8'h01, D, 8'h00, E, 2'b00, 2'b00, 32'h0, 3'b101, 8'h01, D));
      tbl.push_back(mk(2'b10, 2'b11, 8'h01, D, 8'h00, E, 2'b00, 2'b01, 32'h0, 3'b100, 8'h01, D));
      tbl.push_back(mk(2'b10, 2'b11, 8'h01, D, 8'h00, E, 2'b10, 2'b00, 32'h0, 3'b000, 8'h01, D));
      tbl.push_back(mk(2'b00, 2'b11, 8'h01, D, 8'h00, E, 2'b00, 2'b00, 32'h0, 3'b101, 8'h00, E));
      tbl.push_back(mk(2'b00, 2'b11, 8'h01, D, 8'h00, E, 2'b00, 2'b10, 32'h0, 3'b100, 8'h00, E));
      tbl.push_back(mk(2'b10, 2'b00, 8'h01, D, 8'h01, 0, 2'b10, 2'b00, 32'h0, 3'b000, 8'h00, E));
      tbl.push_back(mk(2'b00, 2'b00, 8'h01, D, 8'h01, 0, 2'b00, 2'b00, 32'h0, 3'b110, 8'h01, 0));
      tbl.push_back(mk(2'b00, 2'b00, 8'h01, D, 8'h01, 0, 2'b00, 2'b10, D, 3'b100, 8'h01, 0));
      for (int t = 0; t < 3; t++) begin
         tbl.push_back(mk(2'b11, 2'b00, 8'h00, 0, 8'h01, 0, 2'b01, 2'b00, D, 3'b000, 8'h01, 0));
         tbl.push_back(mk(2'b11, 2'b00, 8'h00, 0, 8'h01, 0, 2'b00, 2'b00, D, 3'b110, 8'h00, 0));
         tbl.push_back(mk(2'b11, 2'b00, 8'h00, 0, 8'h01, 0, 2'b00, 2'b01, E, 3'b100, 8'h00, 0));
         if (t == 2) break;
         tbl.push_back(mk(2'b11, 2'b00, 8'h00, 0, 8'h01, 0, 2'b10, 2'b00, E, 3'b000, 8'h00, 0));
         tbl.push_back(mk(2'b11, 2'b00, 8'h00, 0, 8'h01, 0, 2'b00, 2'b00, E, 3'b110, 8'h01, 0));
         tbl.push_back(mk(2'b11, 2'b00, 8'h00, 0, 8'h01, 0, 2'b00, 2'b10, D, 3'b100, 8'h01, 0));
      end
      tbl.push_back(mk(2'b11, 2'b00, 8'h00, 0, 8'h01, 0, 2'b10, 2'b00, E, 3'b000, 8'h00, 0));
      tbl.push_back(mk(2'b00, 2'b00, 8'h00, 0, 8'h01, 0, 2'b00, 2'b00, E, 3'b110, 8'h01, 0));
      tbl.push_back(mk(2'b00, 2'b00, 8'h00, 0, 8'h01, 0, 2'b00, 2'b10, D, 3'b100, 8'h01, 0));
      tbl.push_back(mk(2'b01, 2'b01, 8'h02, C, 8'h01, 0, 2'b01, 2'b00, D, 3'b000, 8'h01, 0));
      for (int t = 0; t < 2; t++) begin
         tbl.push_back(mk(2'b01, 2'b01, 8'h02, C, 8'h01, 0, 2'b00, 2'b00, t == 0 ? D : 32'h0,
                          3'b101, 8'h02, C));
         tbl.push_back(mk(2'b01, 2'b01, 8'h02, C, 8'h01, 0, 2'b00, 2'b01, 32'h0, 3'b100, 8'h02, C));
         tbl.push_back(mk(2'b01, 2'b01, 8'h02, C, 8'h01, 0, 2'b01, 2'b00, 32'h0, 3'b000, 8'h02, C));
      end
      tbl.push_back(mk(2'b00, 2'b01, 8'h02, C, 8'h01, 0, 2'b00, 2'b00, 32'h0, 3'b101, 8'h02, C));
      tbl.push_back(mk(2'b00, 2'b01, 8'h02, C, 8'h01, 0, 2'b00, 2'b01, 32'h0, 3'b100, 8'h02, C));
      tbl.push_back(mk(2'b00, 2'b01, 8'h02, C, 8'h01, 0, 2'b00, 2'b00, 32'h0, 3'b000, 8'h02, C));

      // Reset state, with requests already pending
      #2;
      chk_obs("reset_a_async", obs_a, '0);
      chk("reset_b_busy", 32'(bsy_b), 32'd0);
      @(negedge clk);
      chk_obs("reset_a_clocked", obs_a, '0);
      chk("reset_b_ready", 32'(rdy_b), 32'd0);
      @(posedge clk); #1;
      rst_a_n = 1'b1;

      foreach (tbl[i]) begin
         v_a = tbl[i].v; w_a = tbl[i].w;
         addr_a = {tbl[i].a1, tbl[i].a0}; data_a = {tbl[i].d1, tbl[i].d0};
         @(negedge clk);
         chk_obs($sformatf("row%0d", i), obs_a, tbl[i].exp);
         @(posedge clk); #1;
      end

      // Random traffic on A against a transaction-level model
      m_phase = 0; m_last = 0; m_g = 0; m_w = 1'b0;
      m_ca = 8'h02; m_cd = C; m_rd = 32'h0; acc = '0;
      for (int i = 0; i < 256; i++) model_mem[i] = mem_a[i];
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) v_a[i] = 1'b0;
            else if (!v_a[i]) begin
               if ($urandom_range(1, 0) == 1) begin
                  v_a[i] = 1'b1;
                  w_a[i] = 1'($urandom_range(1, 0));
                  addr_a[i*8 +: 8] = 8'($urandom_range(3, 0));
                  data_a[i*32 +: 32] = $urandom;
               end
            end else if ($urandom_range(15, 0) == 0) v_a[i] = 1'b0;
         end
         @(negedge clk);
         exp_o = '0; exp_o.ca = m_ca; exp_o.cd = m_cd; exp_o.rd = m_rd;
         case (m_phase)
            0: begin
               if (v_a != 2'b00) begin
                  m_g = rr_pick(v_a, m_last);
                  exp_o.rdy = 2'(32'd1 << m_g);
                  m_last = m_g; m_w = w_a[m_g];
                  m_ca = addr_a[m_g*8 +: 8]; m_cd = data_a[m_g*32 +: 32];
                  m_phase = 1;
               end
            end
            1: begin
               exp_o.bsy = 1'b1; exp_o.cwr = m_w; exp_o.crd = !m_w;
               if (m_w) begin
                  model_mem[m_ca] = m_cd;
                  m_rd = 32'h0;
               end else m_rd = model_mem[m_ca];
               m_phase = 2;
            end
            default: begin
               exp_o.bsy = 1'b1; exp_o.rv = 2'(32'd1 << m_g);
               m_phase = 0;
            end
         endcase
         chk_obs($sformatf("rand%0d", n), obs_a, exp_o);
         acc = rdy_a;
         @(posedge clk); #1;
      end
      v_a = '0;

      // Test 4: READ_LATENCY=2 single read
      rst_b_n = 1'b1; v_b = 2'b01; w_b = 2'b00; addr_b = 16'h0010;
      @(negedge clk);
      chk("t4_accept", 32'(rdy_b), 32'd1);
      c0 = cyc;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         v_b = 2'b00;
         @(negedge clk);
         chk($sformatf("t4_cread%0d", k), 32'(crd_b), 32'(k <= 3));
         chk($sformatf("t4_rsp%0d", k), 32'(rv_b), (k == 4) ? 32'd1 : 32'd0);
         chk($sformatf("t4_busy%0d", k), 32'(bsy_b), 32'(k <= 4));
         if (k <= 3) chk($sformatf("t4_addr%0d", k), 32'(ca_b), 32'h10);
         if (k == 4) chk("t4_data", rd_b, 32'h10 + c0 + 32'd3);
      end

      // Test 5: reset while waiting on read data
      @(posedge clk); #1;
      v_b = 2'b01; addr_b = 16'h0020;
      @(negedge clk);
      chk("t5_accept", 32'(rdy_b), 32'd1);
      @(posedge clk); #1;
      v_b = 2'b00;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_in_wait", 32'({crd_b, bsy_b}), 32'b11);
      #2;
      rst_b_n = 1'b0;
      #1;
      chk("t5_async_cread", 32'(crd_b), 32'd0);
      chk("t5_async_busy", 32'(bsy_b), 32'd0);
      chk("t5_async_rsp", 32'(rv_b), 32'd0);
      v_b = 2'b11;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("t5_held%0d", k), 32'({rv_b, rdy_b, crd_b}), 32'd0);
      end
      @(posedge clk); #1;
      rst_b_n = 1'b1;
      @(negedge clk);
      chk("t5_regrant", 32'(rdy_b), 32'd1);
      @(posedge clk); #1;
      v_b = 2'b00;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
